muldiv_iter: RTL and testbench

Parametrised multi-cycle multiply/divide unit that replaces the fixed-width external divider and the pipelined multiplier instanced beside the EX-stage ALU. It executes signed/unsigned multiply and divide with a single shift-and-add / restoring-subtract datapath over WIDTH iterations. It raises a stall request toward the pipeline control while busy, and supports annulment on flush. Results are presented as a {HI, LO} pair for the HI/LO write path.

---
 rtl/muldiv_iter.sv | 140 ++++++++++++++
 tb/tb_muldiv_iter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and divide for the EX stage.
// One shift-add or restoring-subtract step per cycle; results as {HI, LO}.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic               stallreq_o,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_by_zero_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic               is_div;
    logic               neg_lo, neg_hi;
    logic [WIDTH-1:0]   opa, acc, lo;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prev_result;
    logic               prev_dbz;

    logic               accept, sgn, s1, s2, div_zero, last;
    logic [WIDTH-1:0]   mag1, mag2, acc_n, lo_n, fin_hi, fin_lo;
    logic [WIDTH:0]     sum, tmp, diff;
    logic [2*WIDTH-1:0] prod;

    assign accept   = (state == IDLE) && start_i && !annul_i;
    assign sgn      = !op_i[0];
    assign s1       = sgn && opdata1_i[WIDTH-1];
    assign s2       = sgn && opdata2_i[WIDTH-1];
    assign mag1     = s1 ? -opdata1_i : opdata1_i;
    assign mag2     = s2 ? -opdata2_i : opdata2_i;
    assign div_zero = op_i[1] && (opdata2_i == '0);
    assign last     = (cnt == CW'(WIDTH - 1));

    assign busy_o     = (state == CALC);
    assign ready_o    = (state == DONE) && !annul_i;
    assign stallreq_o = accept || (state == CALC);

    // One iteration step plus the sign-corrected view of its outcome
    always_comb begin
        sum  = {1'b0, acc} + (lo[0] ? {1'b0, opa} : '0);
        tmp  = {acc, lo[WIDTH-1]};
        diff = tmp - {1'b0, opa};
        if (is_div) begin
            acc_n = diff[WIDTH] ? tmp[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_n  = {lo[WIDTH-2:0], !diff[WIDTH]};
        end else begin
            acc_n = sum[WIDTH:1];
            lo_n  = {sum[0], lo[WIDTH-1:1]};
        end
        prod = {acc_n, lo_n};
        if (is_div) begin
            fin_hi = neg_hi ? -acc_n : acc_n;
            fin_lo = neg_lo ? -lo_n : lo_n;
        end else begin
            prod   = neg_lo ? -prod : prod;
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = div_zero ? DONE : CALC;
            CALC: begin
                if (annul_i)   state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div        <= 1'b0;
            neg_lo        <= 1'b0;
            neg_hi        <= 1'b0;
            opa           <= '0;
            acc           <= '0;
            lo            <= '0;
            cnt           <= '0;
            result_o      <= '0;
            div_by_zero_o <= 1'b0;
            prev_result   <= '0;
            prev_dbz      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    is_div <= op_i[1];
                    neg_lo <= s1 ^ s2;
                    neg_hi <= op_i[1] ? s1 : (s1 ^ s2);
                    opa    <= op_i[1] ? mag2 : mag1;
                    lo     <= op_i[1] ? mag1 : mag2;
                    acc    <= '0;
                    cnt    <= '0;
                    if (div_zero) begin
                        prev_result   <= result_o;
                        prev_dbz      <= div_by_zero_o;
                        result_o      <= '0;
                        div_by_zero_o <= 1'b1;
                    end
                end
                CALC: if (!annul_i) begin
                    acc <= acc_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        prev_result   <= result_o;
                        prev_dbz      <= div_by_zero_o;
                        result_o      <= {fin_hi, fin_lo};
                        div_by_zero_o <= 1'b0;
                    end
                end
                // A flushed result must not become architecturally visible
                DONE: if (annul_i) begin
                    result_o      <= prev_result;
                    div_by_zero_o <= prev_dbz;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized scoreboard bench for muldiv_iter at WIDTH=32 and WIDTH=8.
// Expected {dbz, HI, LO} values come from plain integer arithmetic.
module tb_muldiv_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        start32, annul32, stall32, busy32, ready32, dbz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        start8, annul8, stall8, busy8, ready8, dbz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    int          vectors = 0;
    int          miscompares = 0;
    logic [64:0] q32[$];
    logic [64:0] q8[$];
    logic [64:0] last_exp;
    logic [64:0] got;
    bit          sel;
    logic        ready_m, stall_m, busy_m;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .op_i(op32),
        .opdata1_i(a32), .opdata2_i(b32), .annul_i(annul32),
        .stallreq_o(stall32), .busy_o(busy32), .ready_o(ready32),
        .result_o(res32), .div_by_zero_o(dbz32)
    );

    muldiv_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .op_i(op8),
        .opdata1_i(a8), .opdata2_i(b8), .annul_i(annul8),
        .stallreq_o(stall8), .busy_o(busy8), .ready_o(ready8),
        .result_o(res8), .div_by_zero_o(dbz8)
    );

    assign ready_m = sel ? ready8 : ready32;
    assign stall_m = sel ? stall8 : stall32;
    assign busy_m  = sel ? busy8 : busy32;

    function automatic logic [64:0] model(input int w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        longint m, ua, ub, sa, sb, p, r;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = (!op[0] && ua[w-1]) ? ua - (longint'(1) << w) : ua;
        sb = (!op[0] && ub[w-1]) ? ub - (longint'(1) << w) : ub;
        if (!op[1]) begin
            p = sa * sb;
            if (w < 32) p = p & ((longint'(1) << (2 * w)) - 1);
            return {1'b0, p};
        end
        if (ub == 0) return {1'b1, 64'd0};
        p = sa / sb;
        r = sa % sb;
        return {1'b0, ((r & m) << w) | (p & m)};
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drives one instruction as the pipeline would, checks its timing
    task automatic issue(input bit is8, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        logic [64:0] e;
        int w, lat, exp_lat;
        bit tok;
        w = is8 ? 8 : 32;
        e = model(w, op, a, b);
        if (is8) q8.push_back(e);
        else     q32.push_back(e);
        last_exp = e;
        sel = is8;
        if (is8) begin
            start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        end
        exp_lat = e[64] ? 1 : w + 1;
        lat = 0;
        tok = 1'b1;
        while (lat <= w + 3) begin
            #1;
            if (ready_m) break;
            if (!stall_m || (busy_m !== (lat > 0))) tok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (stall_m || busy_m) tok = 1'b0;
        got = is8 ? {dbz8, 48'd0, res8} : {dbz32, res32};
        check("latency", 65'(lat), 65'(exp_lat));
        check("stall_busy", {64'd0, tok}, 65'd1);
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [64:0] e;
        if (ready32) begin
            vectors++;
            if (q32.size() == 0) begin
                miscompares++;
                $display("FAIL ready32_unexpected: got result %h expected no ready", res32);
            end else begin
                e = q32.pop_front();
                if ({dbz32, res32} !== e) begin
                    miscompares++;
                    $display("FAIL result32: got %h expected %h", {dbz32, res32}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [64:0] e;
        if (ready8) begin
            vectors++;
            if (q8.size() == 0) begin
                miscompares++;
                $display("FAIL ready8_unexpected: got result %h expected no ready", res8);
            end else begin
                e = q8.pop_front();
                if ({dbz8, res8} !== {e[64], e[15:0]}) begin
                    miscompares++;
                    $display("FAIL result8: got %h expected %h", {dbz8, res8}, {e[64], e[15:0]});
                end
            end
        end
    end

    logic [1:0]  d_op[7]  = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [31:0] d_a[7]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000,
                              32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5};
    logic [31:0] d_b[7]   = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000,
                              32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0};
    logic [64:0] d_exp[7] = '{{1'b0, 64'hFFFF_FFFE_0000_0001},
                              {1'b0, 64'hFFFF_FFFF_FFFF_FFEB},
                              {1'b0, 64'h4000_0000_0000_0000},
                              {1'b0, 64'hFFFF_FFFF_FFFF_FFFD},
                              {1'b0, 64'h0000_0002_0000_000E},
                              {1'b0, 64'h0000_0000_8000_0000},
                              {1'b1, 64'h0}};

    initial begin
        rst = 1'b1; sel = 1'b0;
        start32 = 0; annul32 = 0; op32 = 0; a32 = 0; b32 = 0;
        start8 = 0; annul8 = 0; op8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_res32", {dbz32, res32}, 65'd0);
        check("reset_flags32", {62'd0, ready32, busy32, stall32}, 65'd0);
        check("reset_res8", {48'd0, dbz8, res8}, 65'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            issue(1'b0, d_op[i], d_a[i], d_b[i]);
            check("directed", got, d_exp[i]);
        end

        // Flush a divide at CALC cycle 10; previous outputs must survive
        sel = 1'b0;
        start32 = 1'b1; op32 = 2'b10; a32 = 32'd1000; b32 = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        annul32 = 1'b1; start32 = 1'b0;
        #1;
        check("annul_busy", {63'd0, busy32, ready32}, 65'd2);
        @(posedge clk);
        #1;
        annul32 = 1'b0;
        #1;
        check("annul_idle", {63'd0, busy32, ready32}, 65'd0);
        check("annul_hold", {dbz32, res32}, last_exp);
        issue(1'b0, 2'b11, 32'd100, 32'd7);

        // Start with annul in IDLE must be ignored
        start32 = 1'b1; annul32 = 1'b1; op32 = 2'b00; a32 = 3; b32 = 3;
        #1;
        check("idle_annul_stall", {64'd0, stall32}, 65'd0);
        @(posedge clk);
        #1;
        start32 = 1'b0; annul32 = 1'b0;
        #1;
        check("idle_annul_busy", {64'd0, busy32}, 65'd0);

        for (int i = 0; i < 40; i++)
            issue(1'b0, 2'($urandom_range(0, 3)), pick(), pick());

        // Asynchronous reset in the middle of CALC
        sel = 1'b0;
        start32 = 1'b1; op32 = 2'b01; a32 = 32'd12345; b32 = 32'd678;
        repeat (5) @(posedge clk);
        #1;
        start32 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_res", {dbz32, res32}, 65'd0);
        check("async_rst_flags", {62'd0, ready32, busy32, stall32}, 65'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(1'b1, 2'b00, 32'h80, 32'hFF);
        check("w8_mult", {got[64], got[15:0]}, {1'b0, 16'h0080});
        for (int i = 0; i < 12; i++)
            issue(1'b1, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 255)),
                  32'($urandom_range(0, 255)));

        repeat (3) @(posedge clk);
        #1;
        check("q32_drained", 65'(q32.size()), 65'd0);
        check("q8_drained", 65'(q8.size()), 65'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
